// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the multi-cycle divider.
package divider_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/adder_subtractor32bit.sv
// 32-bit ripple adder/subtractor. MuxSel=1 inverts B and injects the +1 of
// two's complement internally, so with C_in=0 the unit computes A-B and
// C_out=1 means no borrow (A >= B).
module adder_subtractor32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MuxSel,
    input  logic        C_in,
    output logic [31:0] O,
    output logic        C_out
);

    logic [32:0] carry;
    logic [31:0] b_eff;

    assign carry[0] = C_in ^ MuxSel;

    // One full-adder cell per bit; carry ripples upward.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bit
            assign b_eff[gi]     = B[gi] ^ MuxSel;
            assign O[gi]         = A[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi + 1] = (A[gi] & b_eff[gi]) | (carry[gi] & (A[gi] ^ b_eff[gi]));
        end
    endgenerate

    assign C_out = carry[32];

endmodule

// File: rtl/restoring_divider32.sv
// Unsigned 32/32 restoring divider: one trial subtraction per cycle through a
// single shared adder/subtractor, 32 iterations per result.
module restoring_divider32
    import divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] Dividend,
    input  logic [DIV_W-1:0] Divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [DIV_W-1:0] Quotient,
    output logic [DIV_W-1:0] Remainder
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Partial remainder. Its 33rd bit is always zero between iterations
    // (the remainder never reaches the divisor), so only 32 bits are stored.
    logic [DIV_W-1:0] r_q, r_d;
    // Starts holding the dividend; dividend bits leave at the top while
    // quotient bits enter at the bottom.
    logic [DIV_W-1:0] q_q, q_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic [DIV_W-1:0] quot_q, quot_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [DIV_W:0]   s_shift;
    logic [DIV_W-1:0] sub_o;
    logic             sub_cout;
    logic             qb;

    // Shifted partial remainder for this iteration.
    assign s_shift = {r_q, q_q[DIV_W-1]};

    adder_subtractor32bit u_addsub (
        .A      (s_shift[DIV_W-1:0]),
        .B      (divisor_q),
        .MuxSel (1'b1),
        .C_in   (1'b0),
        .O      (sub_o),
        .C_out  (sub_cout)
    );

    // A set top bit means S exceeds any 32-bit divisor, so the trial succeeds.
    assign qb = s_shift[DIV_W] | sub_cout;

    // Next-state: start capture, one restoring step per RUN cycle, result load.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        r_d       = r_q;
        q_d       = q_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    divisor_d = Divisor;
                    r_d       = '0;
                    q_d       = Dividend;
                    count_d   = CNT_W'(DIV_W - 1);
                    dbz_d     = 1'b0;
                    if (Divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = Dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d     = qb ? sub_o : s_shift[DIV_W-1:0];
                q_d     = {q_q[DIV_W-2:0], qb};
                count_d = count_q - CNT_W'(1);
                if (count_q == '0) begin
                    state_d = DONE;
                    quot_d  = {q_q[DIV_W-2:0], qb};
                    rem_d   = qb ? sub_o : s_shift[DIV_W-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            r_q       <= '0;
            q_q       <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            r_q       <= r_d;
            q_q       <= q_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign Quotient    = quot_q;
    assign Remainder   = rem_q;

endmodule

// File: tb/tb_restoring_divider32.sv
// Scoreboard bench for restoring_divider32: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_restoring_divider32;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
        int          busy_n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] Quotient;
    logic [31:0] Remainder;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    exp_t last_exp;

    restoring_divider32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .Quotient    (Quotient),
        .Remainder   (Remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: plain integer division with the zero-divisor rule.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int cyc_now);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
            e.cyc = cyc_now + 1; e.busy_n = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
            e.cyc = cyc_now + 33; e.busy_n = 32;
        end
        return e;
    endfunction

    // Monitor: compares each done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy && done) begin
                n_tests++; n_fail++;
                $display("FAIL busy_done_overlap: busy=1 done=1 at cycle %0d", cyc);
            end
            if (busy) busy_cnt++;
            if (done) begin
                exp_t e;
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] done: Q=%h R=%h dbz=%0b cycle=%0d", Quotient, Remainder, div_by_zero, cyc);
                    check("quotient", Quotient, e.q);
                    check("remainder", Remainder, e.r);
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    check("done_cycle", cyc, e.cyc);
                    check("busy_cycles", busy_cnt, e.busy_n);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive one start just after a negedge; returns one cycle after acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(a, b, cyc);
        exp_q.push_back(e);
        last_exp = e;
        $display("[TB] issue: %h / %h", a, b);
        start = 1'b1; Dividend = a; Divisor = b;
        @(negedge clk); #1;
        start = 1'b0; Dividend = $urandom; Divisor = $urandom;
        if (b != 32'd0) begin
            check("dbz_cleared_on_start", {31'd0, div_by_zero}, 32'd0);
            check("busy_after_start", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk); #1;
        end
        check("drain_outstanding", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        wait_drain();
        @(negedge clk); #1;
        check("held_quotient", Quotient, last_exp.q);
        check("held_remainder", Remainder, last_exp.r);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
        check({tag, "_quotient"}, Quotient, 32'd0);
        check({tag, "_remainder"}, Remainder, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [31:0] a, b;
        rst_n = 1'b0; start = 1'b0; Dividend = '0; Divisor = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;

        run_div(32'd100, 32'd7);
        run_div(32'hFFFF_FFFF, 32'd1);
        run_div(32'hFFFF_FFFF, 32'h8000_0001);
        run_div(32'h8000_0000, 32'hFFFF_FFFF);
        run_div(32'd5, 32'd0);
        run_div(32'd20, 32'd3);

        // Start pulsed during RUN must be ignored.
        d0 = done_cnt;
        issue(32'd100, 32'd7);
        repeat (4) @(negedge clk);
        #1;
        start = 1'b1; Dividend = 32'd9; Divisor = 32'd3;
        @(negedge clk); #1;
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        #1;
        check("ignored_start_done_count", done_cnt - d0, 32'd1);

        // Reset in the tenth RUN cycle discards the division.
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_all_zero("midrun_reset");
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        run_div(32'd50, 32'd5);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            a = $urandom;
            if (sel == 0)      b = 32'd0;
            else if (sel < 4)  b = $urandom_range(1, 255);
            else if (sel < 6)  b = a + $urandom_range(0, 3);
            else               b = $urandom;
            if (sel == 9) a = $urandom_range(0, 1000);
            run_div(a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/restoring_divider32.md
# restoring_divider32

Multi-cycle unsigned 32-bit integer divider that sequences the team's existing `adder_subtractor32bit` unit as its only arithmetic resource. It runs one trial subtraction per cycle and takes 32 cycles per quotient. It is intended as the DIV/REM execution unit alongside the single-cycle ALU, with a start/busy/done handshake toward the issuing control logic.

## Interface
Parameters:
- none; width is fixed at 32. Constants live in the shared package.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division. Sampled only in IDLE.
- `Dividend`  in  32  unsigned dividend, captured when `start` is accepted.
- `Divisor`  in  32  unsigned divisor, captured when `start` is accepted.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse, high in DONE.
- `div_by_zero`  out  1  set in DONE when the captured divisor was 0. Held until the next accepted start.
- `Quotient`  out  32  result quotient. Valid from DONE and held until the next accepted start.
- `Remainder`  out  32  result remainder. Same validity as `Quotient`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN when `start`=1 and the divisor is nonzero.
  - IDLE to DONE when `start`=1 and the divisor is 0.
  - RUN to DONE after the iteration with count 0.
  - DONE to IDLE unconditionally.
- Start acceptance:
  - `start` is accepted only in IDLE; it is ignored in RUN and DONE.
  - On acceptance: capture operands; clear R (33-bit partial remainder) and Q; set count to 31; clear `div_by_zero`.
- One RUN iteration (restoring algorithm):
  - Form S = {R[31:0], Q[31]}, 33 bits. Q shifts left by one.
  - Drive the adder/subtractor with A = S[31:0], B = divisor, MuxSel = 1 (subtract), C_in = 0.
  - Its C_out = 1 means A ≥ B (no borrow).
  - Quotient bit qb = S[32] OR C_out.
  - If qb = 1: R ← {1'b0, O}. Otherwise R ← S.
  - Q[0] ← qb; count decrements.
  - When S[32] = 1 the subtraction always succeeds and O is the correct low 32 bits, because the true remainder is always < divisor.
- Divide by zero:
  - No iterations run.
  - In DONE: `Quotient` = 32'hFFFFFFFF, `Remainder` = dividend, `div_by_zero` = 1.
- Operand changes after acceptance have no effect.
- Outputs `Quotient`/`Remainder` are registers. They update only on entry to DONE and are held through IDLE.
- Reset asserted at any point, including mid-RUN:
  - FSM goes to IDLE immediately; any in-flight result is discarded.
  - All outputs return to 0: `busy`, `done`, `div_by_zero`, `Quotient`, `Remainder`.

## Timing
- Normal divide: `start` sampled at edge k. `busy` is high for cycles k+1..k+32 (32 RUN cycles). DONE is at cycle k+33, with `done`=1 and results valid. IDLE from k+34.
- Divide by zero: `start` sampled at edge k; DONE at k+1.
- Back-to-back: the earliest next accepted `start` is at the edge ending the first IDLE cycle after DONE. Minimum period is 34 cycles.
- The adder/subtractor path is combinational within a RUN cycle: register → unit → register, one cycle.
- `busy` and `done` are never high together.

## Structure
- Shared package `divider_pkg`:
  - `DIV_W` = 32 and `CNT_W` = 5.
  - State enum `div_state_t`: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
- Sub-module: one instance of the existing `adder_subtractor32bit`, hard-wired to subtract mode (MuxSel = 1, C_in = 0). No new sub-modules.
- Remainder mux, quotient shift register, counter and FSM all sit in this block.

## Test plan
- Basic divide: 100 / 7 → `Quotient`=14, `Remainder`=2. `done` exactly 33 cycles after start; `busy` high for exactly 32 cycles.
- MSB path: 32'hFFFFFFFF / 1 → Q=32'hFFFFFFFF, R=0. 32'hFFFFFFFF / 32'h80000001 → Q=1, R=32'h7FFFFFFE.
- Divisor larger than dividend: 32'h80000000 / 32'hFFFFFFFF → Q=0, R=32'h80000000.
- Divide by zero: 5 / 0 → `done` 1 cycle after start, `div_by_zero`=1, Q=32'hFFFFFFFF, R=5. The next valid divide clears `div_by_zero`.
- Ignored start: pulse `start` with 9 / 3 during RUN of 100 / 7. The result is still 14 r 2, and no extra `done` occurs.
- Reset mid-run: deassert `rst_n` at RUN cycle 10. All outputs read 0 immediately and the FSM is in IDLE. After release, 50 / 5 gives Q=10, R=0.
